// File: rtl/stack_pointer_unit_if.sv
// Stack-pointer unit bundle: op request and pipeline control in, stack access and SP status out.
// master = upstream pipeline/decode side, slave = stack_pointer_unit side.
interface stack_pointer_unit_if #(
    parameter int SP_WIDTH = 32
);
    logic                stall;
    logic                flush;
    logic                is_stack_op;
    logic                stack_op;
    logic                two_word;
    logic [SP_WIDTH-1:0] mem_addr;
    logic                mem_en;
    logic                word_sel;
    logic [SP_WIDTH-1:0] sp;
    logic                busy;
    logic                stack_fault;

    modport master (
        output stall, flush, is_stack_op, stack_op, two_word,
        input  mem_addr, mem_en, word_sel, sp, busy, stack_fault
    );

    modport slave (
        input  stall, flush, is_stack_op, stack_op, two_word,
        output mem_addr, mem_en, word_sel, sp, busy, stack_fault
    );
endinterface

// File: rtl/stack_pointer_unit.sv
// Architectural SP register plus stack address generation; two-word ops sequenced by an IDLE/SECOND FSM.
// Latency: push/pop 1 cycle, two-word op 2 cycles with busy high in the first; stall holds, flush aborts/rolls back.
// Optional macro STACK_GUARD_EN: suppress overflow/underflow accesses and raise a sticky stack_fault.
module stack_pointer_unit #(
    parameter int                  SP_WIDTH = 32,
    parameter logic [SP_WIDTH-1:0] SP_RESET = 32'h000F_FFFF,
    parameter logic [SP_WIDTH-1:0] SP_LIMIT = 32'h000F_F000
) (
    input  logic                 clk,
    input  logic                 rst,
    stack_pointer_unit_if.slave  bus
);
    typedef enum logic {ST_IDLE, ST_SECOND} state_t;

    localparam logic [SP_WIDTH-1:0] ONE = 1;

    state_t              r_state;
    logic [SP_WIDTH-1:0] r_sp;
    logic [SP_WIDTH-1:0] r_sp_save;
    logic                r_pop;

    logic                w_second;
    logic                w_pop;
    logic                w_active;
    logic                w_fault_hit;
    logic [SP_WIDTH-1:0] w_sp_inc;
    logic [SP_WIDTH-1:0] w_sp_dec;
    logic [SP_WIDTH-1:0] w_sp_next;
    logic [SP_WIDTH-1:0] w_addr;

    // In SECOND the direction comes from the latched op; the live op fields belong to the held instruction.
    assign w_second  = (r_state == ST_SECOND);
    assign w_pop     = w_second ? r_pop : bus.stack_op;
    assign w_active  = w_second | bus.is_stack_op;
    assign w_sp_inc  = r_sp + ONE;
    assign w_sp_dec  = r_sp - ONE;
    assign w_sp_next = w_pop ? w_sp_inc : w_sp_dec;
    assign w_addr    = w_pop ? w_sp_inc : r_sp;

`ifdef STACK_GUARD_EN
    logic r_fault;

    assign w_fault_hit = w_active & (w_pop ? (r_sp == SP_RESET) : (r_sp == SP_LIMIT));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fault <= 1'b0;
        end else if (!bus.flush && !bus.stall && w_fault_hit) begin
            r_fault <= 1'b1;
        end
    end

    assign bus.stack_fault = r_fault;
`else
    logic w_unused_limit;

    assign w_fault_hit     = 1'b0;
    assign w_unused_limit  = ^SP_LIMIT;
    assign bus.stack_fault = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_sp      <= SP_RESET;
            r_sp_save <= SP_RESET;
            r_pop     <= 1'b0;
        end else if (bus.flush) begin
            // Aborting the second word undoes the first word's SP move.
            if (w_second) begin
                r_sp <= r_sp_save;
            end
            r_state <= ST_IDLE;
        end else if (!bus.stall && w_active) begin
            if (w_fault_hit) begin
                if (w_second) begin
                    r_sp <= r_sp_save;
                end
                r_state <= ST_IDLE;
            end else begin
                r_sp <= w_sp_next;
                if (!w_second && bus.two_word) begin
                    r_state   <= ST_SECOND;
                    r_pop     <= bus.stack_op;
                    r_sp_save <= r_sp;
                end else begin
                    r_state <= ST_IDLE;
                end
            end
        end
    end

    assign bus.sp       = r_sp;
    assign bus.mem_addr = w_active ? w_addr : r_sp;
    assign bus.mem_en   = w_active & ~w_fault_hit & ~bus.stall & ~bus.flush;
    assign bus.word_sel = w_second;
    assign bus.busy     = ~w_second & bus.is_stack_op & bus.two_word & ~w_fault_hit & ~bus.flush;
endmodule
